// File: rtl/mp_result_monitor.sv
// Result history monitor: captures {R2,R1,R0} triples into a circular buffer,
// lets the user step back through them, and scans the viewed entry onto a 4-digit display.
module mp_result_monitor #(
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [3:0]        R0,
  input  logic [3:0]        R1,
  input  logic [3:0]        R2,
  input  logic              CAP,
  input  logic              PREV,
  output logic [3:0]        AN,
  output logic [6:0]        SEG,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ENTRY_W = 12;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  logic               cap_q;
  logic               prev_q;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  offset;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         dig;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               cap_edge;
  logic               prev_edge;
  logic [CNT_W-1:0]   count_nxt;
  logic [ADDR_W-1:0]  view_idx;
  logic [ENTRY_W-1:0] entry;
  logic [3:0]         nib;
  logic [6:0]         seg_nxt;
  logic [3:0]         an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Edge detection and capture bookkeeping; a capture suppresses a same-cycle step.
  always_comb begin
    cap_edge  = CAP & ~cap_q;
    prev_edge = PREV & ~prev_q & ~cap_edge;
    count_nxt = COUNT;
    if (cap_edge && (COUNT != CNT_W'(DEPTH)))
      count_nxt = COUNT + CNT_W'(1);
  end

  // Display content for the currently indexed digit.
  always_comb begin
    view_idx = wr_ptr - ADDR_W'(1) - offset;
    entry    = mem[view_idx];
    nib      = 4'(offset);
    case (dig)
      2'd0:    nib = entry[3:0];
      2'd1:    nib = entry[7:4];
      2'd2:    nib = entry[11:8];
      default: nib = 4'(offset);
    endcase
    if ((COUNT == '0) && (dig != 2'd3))
      seg_nxt = 7'b1111111;
    else
      seg_nxt = hex7(nib);
    an_nxt = ~(4'b0001 << dig);
  end

  // History storage is not reset; it is hidden while COUNT is zero.
  always_ff @(posedge CLK) begin
    if (!CLR && cap_edge)
      mem[wr_ptr] <= {R2, R1, R0};
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cap_q    <= CAP;
      prev_q   <= PREV;
      wr_ptr   <= '0;
      offset   <= '0;
      scan_cnt <= '0;
      dig      <= 2'd0;
      COUNT    <= '0;
      FULL     <= 1'b0;
      AN       <= 4'b1110;
      SEG      <= 7'b1111111;
    end else begin
      cap_q  <= CAP;
      prev_q <= PREV;
      AN     <= an_nxt;
      SEG    <= seg_nxt;
      COUNT  <= count_nxt;
      FULL   <= (count_nxt == CNT_W'(DEPTH));

      if (cap_edge) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        offset <= '0;
      end else if (prev_edge && (COUNT != '0)) begin
        if ({1'b0, offset} == (COUNT - CNT_W'(1)))
          offset <= '0;
        else
          offset <= offset + ADDR_W'(1);
      end

      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig      <= dig + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mp_result_monitor.sv
// Directed self-checking bench for mp_result_monitor: scan order, capture, history
// stepping, capture/step collision, level holding and mid-operation reset.
module tb_mp_result_monitor;

  localparam int unsigned SCAN_DIV = 16;
  localparam int unsigned LIMIT    = 4 * SCAN_DIV + 4;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] R0 = 4'h0;
  logic [3:0] R1 = 4'h0;
  logic [3:0] R2 = 4'h0;
  logic       CAP = 1'b0;
  logic       PREV = 1'b0;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic [3:0] COUNT;
  logic       FULL;

  int passed = 0;
  int total  = 0;

  mp_result_monitor #(.SCAN_DIV(SCAN_DIV), .DEPTH(8), .ADDR_W(3)) dut (
    .CLK(CLK), .CLR(CLR), .R0(R0), .R1(R1), .R2(R2), .CAP(CAP), .PREV(PREV),
    .AN(AN), .SEG(SEG), .COUNT(COUNT), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Bounded wait until the given digit is selected; callers then compare AN themselves.
  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (AN !== target && n < LIMIT) begin
      tick(1);
      n++;
    end
  endtask

  task automatic capture(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    R0 = r0; R1 = r1; R2 = r2;
    CAP = 1'b1; tick(1);
    CAP = 1'b0; tick(1);
  endtask

  task automatic step_prev();
    PREV = 1'b1; tick(1);
    PREV = 1'b0; tick(1);
  endtask

  task automatic do_reset();
    CLR = 1'b1; tick(1);
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] an_seq [4];
    logic [6:0] seg_seq [4];
    logic [3:0] prev_an;
    int n;
    an_seq  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_seq = '{7'b1111111, 7'b1111111, 7'b1000000, 7'b1111111};
    CLR = 1'b1; tick(2);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b1111111 || COUNT !== 4'd0 || FULL !== 1'b0)
      $display("FAIL reset_state: AN=%b SEG=%b COUNT=%0d FULL=%b want 1110 1111111 0 0", AN, SEG, COUNT, FULL);
    else passed++;
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prev_an = AN;
      n = 0;
      while (AN === prev_an && n < LIMIT) begin
        tick(1);
        n++;
      end
      total++;
      if (AN !== an_seq[i] || SEG !== seg_seq[i])
        $display("FAIL scan_step%0d: AN=%b SEG=%b want %b %b", i, AN, SEG, an_seq[i], seg_seq[i]);
      else passed++;
      if (i > 0) begin
        total++;
        if (n != SCAN_DIV)
          $display("FAIL scan_hold%0d: held %0d cycles want %0d", i, n, SCAN_DIV);
        else passed++;
      end
    end
    step_prev();
    wait_an(4'b0111);
    total++;
    if (AN !== 4'b0111 || SEG !== 7'b1000000 || COUNT !== 4'd0)
      $display("FAIL prev_when_empty: AN=%b SEG=%b COUNT=%0d want 0111 1000000 0", AN, SEG, COUNT);
    else passed++;
  endtask

  task automatic test_single_capture();
    logic [3:0] an_t [4];
    logic [6:0] seg_t [4];
    an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_t = '{7'b0010010, 7'b0001000, 7'b1111001, 7'b1000000};
    capture(4'h5, 4'hA, 4'h1);
    total++;
    if (COUNT !== 4'd1 || FULL !== 1'b0)
      $display("FAIL single_count: COUNT=%0d FULL=%b want 1 0", COUNT, FULL);
    else passed++;
    for (int d = 0; d < 4; d++) begin
      wait_an(an_t[d]);
      total++;
      if (AN !== an_t[d] || SEG !== seg_t[d])
        $display("FAIL single_digit%0d: AN=%b SEG=%b want %b %b", d, AN, SEG, an_t[d], seg_t[d]);
      else passed++;
    end
  endtask

  task automatic test_history();
    for (int i = 0; i < 10; i++) capture(4'(i), 4'(i), 4'hF);
    total++;
    if (COUNT !== 4'd8 || FULL !== 1'b1)
      $display("FAIL hist_full: COUNT=%0d FULL=%b want 8 1", COUNT, FULL);
    else passed++;
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b0010000)
      $display("FAIL hist_newest: AN=%b SEG=%b want 1110 0010000", AN, SEG);
    else passed++;
    for (int i = 0; i < 7; i++) step_prev();
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b0100100)
      $display("FAIL hist_oldest_r0: AN=%b SEG=%b want 1110 0100100", AN, SEG);
    else passed++;
    wait_an(4'b0111);
    total++;
    if (AN !== 4'b0111 || SEG !== 7'b1111000)
      $display("FAIL hist_offset7: AN=%b SEG=%b want 0111 1111000", AN, SEG);
    else passed++;
    step_prev();
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b0010000)
      $display("FAIL hist_wrap_r0: AN=%b SEG=%b want 1110 0010000", AN, SEG);
    else passed++;
    wait_an(4'b0111);
    total++;
    if (AN !== 4'b0111 || SEG !== 7'b1000000)
      $display("FAIL hist_wrap_offset: AN=%b SEG=%b want 0111 1000000", AN, SEG);
    else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 1; i <= 4; i++) capture(4'(i), 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step_prev();
    wait_an(4'b0111);
    total++;
    if (AN !== 4'b0111 || SEG !== 7'b0110000)
      $display("FAIL sim_pre_offset3: AN=%b SEG=%b want 0111 0110000", AN, SEG);
    else passed++;
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b1111001)
      $display("FAIL sim_pre_r0: AN=%b SEG=%b want 1110 1111001", AN, SEG);
    else passed++;
    R0 = 4'hC;
    CAP = 1'b1; PREV = 1'b1; tick(1);
    CAP = 1'b0; PREV = 1'b0; tick(1);
    total++;
    if (COUNT !== 4'd5 || FULL !== 1'b0)
      $display("FAIL sim_count: COUNT=%0d FULL=%b want 5 0", COUNT, FULL);
    else passed++;
    wait_an(4'b0111);
    total++;
    if (AN !== 4'b0111 || SEG !== 7'b1000000)
      $display("FAIL sim_offset0: AN=%b SEG=%b want 0111 1000000", AN, SEG);
    else passed++;
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b1000110)
      $display("FAIL sim_new_r0: AN=%b SEG=%b want 1110 1000110", AN, SEG);
    else passed++;
  endtask

  task automatic test_clr_mid();
    step_prev();
    step_prev();
    wait_an(4'b1110);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b0110000)
      $display("FAIL clr_pre_r0: AN=%b SEG=%b want 1110 0110000", AN, SEG);
    else passed++;
    wait_an(4'b1011);
    tick(3);
    CLR = 1'b1; tick(1);
    total++;
    if (AN !== 4'b1110 || SEG !== 7'b1111111 || COUNT !== 4'd0 || FULL !== 1'b0)
      $display("FAIL clr_mid: AN=%b SEG=%b COUNT=%0d FULL=%b want 1110 1111111 0 0", AN, SEG, COUNT, FULL);
    else passed++;
    CLR = 1'b0;
  endtask

  task automatic test_hold();
    R0 = 4'h3;
    CAP = 1'b1; tick(50);
    CAP = 1'b0; tick(1);
    total++;
    if (COUNT !== 4'd1)
      $display("FAIL hold_one_capture: COUNT=%0d want 1", COUNT);
    else passed++;
    CAP = 1'b1; tick(1);
    CLR = 1'b1; tick(1);
    CLR = 1'b0; tick(10);
    total++;
    if (COUNT !== 4'd0 || FULL !== 1'b0)
      $display("FAIL hold_across_clr: COUNT=%0d FULL=%b want 0 0", COUNT, FULL);
    else passed++;
    CAP = 1'b0; tick(2);
    total++;
    if (COUNT !== 4'd0)
      $display("FAIL hold_release: COUNT=%0d want 0", COUNT);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_history();
    test_simultaneous();
    test_clr_mid();
    test_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
